uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ requesters
//
// Ports:
//   CLK          clock, all logic on the rising edge
//   RST          synchronous active-high reset
//   REQ_VALID    per-requester send request
//   REQ_DATA     per-requester word, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_PAR_EN   per-requester parity enable
//   REQ_PAR_TYP  per-requester parity type (0 even, 1 odd)
//   REQ_ACK      one-cycle pulse to the requester whose word was issued
//   P_DATA       word driven to the UART transmitter
//   Data_Valid   one-cycle start pulse to the UART transmitter
//   PAR_EN       parity enable to the UART transmitter
//   PAR_TYP      parity type to the UART transmitter
//   Busy         UART transmitter busy flag
//   ACTIVE_ID    index of the last granted requester
//   ERR          sticky: Busy never rose after a start pulse
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
    input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          Data_Valid,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    input  logic                          Busy,
    output logic [$clog2(NUM_REQ)-1:0]    ACTIVE_ID,
    output logic                          ERR
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        last_grant, last_grant_nxt;
    // Counts the busy-check windows already spent in WAIT_BUSY.
    logic                   wb_cnt, wb_cnt_nxt;

    logic [NUM_REQ-1:0]     ack_nxt;
    logic [DATA_WIDTH-1:0]  p_data_nxt;
    logic                   dv_nxt, par_en_nxt, par_typ_nxt, err_nxt;
    logic [ID_W-1:0]        id_nxt;

    logic                   found;
    logic [ID_W-1:0]        winner;

    // Round-robin search starting just above the last winner, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && REQ_VALID[(int'(last_grant) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wb_cnt_nxt     = wb_cnt;
        ack_nxt        = '0;
        dv_nxt         = 1'b0;
        p_data_nxt     = P_DATA;
        par_en_nxt     = PAR_EN;
        par_typ_nxt    = PAR_TYP;
        id_nxt         = ACTIVE_ID;
        err_nxt        = ERR;
        case (state)
            IDLE: begin
                if (found && !Busy) begin
                    state_nxt       = WAIT_BUSY;
                    last_grant_nxt  = winner;
                    wb_cnt_nxt      = 1'b0;
                    ack_nxt[winner] = 1'b1;
                    dv_nxt          = 1'b1;
                    p_data_nxt      = REQ_DATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    par_en_nxt      = REQ_PAR_EN[winner];
                    par_typ_nxt     = REQ_PAR_TYP[winner];
                    id_nxt          = winner;
                end
            end
            // Busy is checked at the two edges following the start pulse:
            // the one ending the Data_Valid cycle and the one after it.
            WAIT_BUSY: begin
                if (Busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wb_cnt) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wb_cnt_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!Busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            wb_cnt     <= 1'b0;
            REQ_ACK    <= '0;
            Data_Valid <= 1'b0;
            P_DATA     <= '0;
            PAR_EN     <= 1'b0;
            PAR_TYP    <= 1'b0;
            ACTIVE_ID  <= '0;
            ERR        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wb_cnt     <= wb_cnt_nxt;
            REQ_ACK    <= ack_nxt;
            Data_Valid <= dv_nxt;
            P_DATA     <= p_data_nxt;
            PAR_EN     <= par_en_nxt;
            PAR_TYP    <= par_typ_nxt;
            ACTIVE_ID  <= id_nxt;
            ERR        <= err_nxt;
        end
    end

endmodule
